// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - bus widths and default reset/bubble words
//   - IF/ID payload struct and the IF/ID register control opcode
//   - word-alignment helper for redirect targets
package if_fetch_unit_pkg;

  localparam int          INST_ADDR_W   = 32;
  localparam int          INST_W        = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST  = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   valid;
  } if_id_t;

  typedef enum logic [1:0] {
    IFID_HOLD  = 2'd0,
    IFID_LOAD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_op_e;

  // Clear the byte offset so a redirect always lands on a word boundary.
  function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] a);
    return {a[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / flush control.
//   clk, rst  : clock, synchronous active-high reset
//   op_i      : IFID_LOAD captures load_i, IFID_HOLD keeps state,
//               IFID_FLUSH inserts a bubble
//   load_i    : fetched {pc, inst, valid}
//   q_o       : registered payload presented to decode
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic     clk,
  input  logic     rst,
  input  ifid_op_e op_i,
  input  if_id_t   load_i,
  output if_id_t   q_o
);

  if_id_t bubble;
  if_id_t ifid_d, ifid_q;

  assign bubble = '{pc: ZERO_WORD, inst: NOP_INST, valid: 1'b0};

  always_comb begin
    ifid_d = ifid_q;
    unique case (op_i)
      IFID_LOAD:  ifid_d = load_i;
      IFID_FLUSH: ifid_d = bubble;
      default:    ifid_d = ifid_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ifid_q <= bubble;
    else     ifid_q <= ifid_d;
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC and ROM chip-enable, registers the
// returned word into IF/ID and counts instructions delivered to decode.
//   clk, rst         : clock, synchronous active-high reset
//   stall_i          : hold PC and IF/ID
//   branch_flag_i    : redirect to branch_target_i (word-aligned), squash IF/ID
//   branch_target_i  : redirect address
//   rom_ce_o         : ROM chip-enable
//   rom_addr_o       : ROM byte address (current PC)
//   rom_inst_i       : combinational ROM read data for rom_addr_o
//   id_pc_o/id_inst_o/id_valid_o : IF/ID contents
//   fetch_cnt_o      : count of valid instructions delivered to decode
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_cnt_o
);

  logic        ce_d, ce_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] fetch_cnt_d, fetch_cnt_q;
  ifid_op_e    ifid_op;
  if_id_t      ifid_load, ifid_out;

  // Priority: chip disabled > redirect > stall > advance.
  // A redirect overrides a stall so the wrong-path word is always squashed.
  always_comb begin
    ce_d        = 1'b1;  // any edge out of reset enables the ROM
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    ifid_op     = IFID_HOLD;
    if (!ce_q) begin
      // ROM output is zero while disabled; decode sees a bubble, not 0x0.
      ifid_op = IFID_FLUSH;
    end else if (branch_flag_i) begin
      pc_d    = align_word(branch_target_i);
      ifid_op = IFID_FLUSH;
    end else if (!stall_i) begin
      pc_d        = pc_q + 32'd4;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      ifid_op     = IFID_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q        <= 1'b0;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= ZERO_WORD;
    end else begin
      ce_q        <= ce_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign ifid_load = '{pc: pc_q, inst: rom_inst_i, valid: 1'b1};

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .op_i   (ifid_op),
    .load_i (ifid_load),
    .q_o    (ifid_out)
  );

  assign rom_ce_o    = ce_q;
  assign rom_addr_o  = pc_q;
  assign id_pc_o     = ifid_out.pc;
  assign id_inst_o   = ifid_out.inst;
  assign id_valid_o  = ifid_out.valid;
  assign fetch_cnt_o = fetch_cnt_q;

endmodule
